// File: rtl/reservoir_pkg.sv
// Shared definitions for the single-node reservoir: sampler FSM state type
// and the default frame geometry used by the delay loop and the readout.
package reservoir_pkg;

  // Default number of virtual nodes per loop round trip
  localparam int RES_N_NODES    = 16;
  // Default number of clock samples taken in each node window
  localparam int RES_OVERSAMPLE = 8;

  // Sampler control state
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SAMPLE = 1'b1
  } state_e;

endpackage : reservoir_pkg

// File: rtl/res_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops reset to 0; q is the output of the second flop.
module res_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain shift through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : res_sync_2ff

// File: rtl/reservoir_node_sampler.sv
// Reservoir node sampler: synchronizes the delay-loop output, slices each
// frame into N_NODES windows of OVERSAMPLE clock samples, counts the high
// samples per window and presents each count on a single-register
// valid/ready output. Sampling never stalls; an unaccepted result is
// overwritten by the next one.
// Optional feature macro: RES_SAMPLER_OVERRUN_EN builds the sticky overrun
// detector; without it the overrun port is tied low.
module reservoir_node_sampler
  import reservoir_pkg::*;
#(
  parameter int N_NODES    = RES_N_NODES,
  parameter int OVERSAMPLE = RES_OVERSAMPLE,
  parameter int IDX_W      = $clog2(N_NODES),
  parameter int CNT_W      = $clog2(OVERSAMPLE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_in,
  input  logic             start,
  output logic             busy,
  output logic             node_valid,
  input  logic             node_ready,
  output logic [IDX_W-1:0] node_idx,
  output logic [CNT_W-1:0] node_count,
  output logic             frame_done,
  output logic             overrun
);

  localparam int               SAMP_W    = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  NODE_LAST = IDX_W'(N_NODES - 1);

  state_e             state_q, state_d;
  logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [IDX_W-1:0]   node_cnt_q, node_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               res_valid_q, res_valid_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               frame_done_q, frame_done_d;

  logic               sync_bit;
  logic               start_accept;
  logic               window_end;
  logic               frame_end;
  logic [CNT_W-1:0]   sample_sum;

  // Loop output crosses into clk here; node windows lag loop_in by 2 cycles
  res_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (loop_in),
    .q     (sync_bit)
  );

  // A start only counts while idle, so restarts mid-frame are ignored
  assign start_accept = (state_q == ST_IDLE) && start;
  assign window_end   = (state_q == ST_SAMPLE) && (samp_cnt_q == SAMP_LAST);
  assign frame_end    = window_end && (node_cnt_q == NODE_LAST);
  // Window total including the sample taken on the closing edge
  assign sample_sum   = acc_q + CNT_W'(sync_bit);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: run one frame per accepted start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start)     state_d = ST_SAMPLE;
      ST_SAMPLE: if (frame_end) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_SAMPLE);
  end

  // Sample/node counters and per-window accumulator
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    node_cnt_d = node_cnt_q;
    acc_d      = acc_q;
    if (start_accept) begin
      samp_cnt_d = '0;
      node_cnt_d = '0;
      acc_d      = '0;
    end else if (state_q == ST_SAMPLE) begin
      if (window_end) begin
        samp_cnt_d = '0;
        acc_d      = '0;
        node_cnt_d = frame_end ? '0 : node_cnt_q + 1'b1;
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
        acc_d      = sample_sum;
      end
    end
  end

  // Output register: a handshake drains it, a new load always wins
  always_comb begin
    res_valid_d  = res_valid_q;
    res_idx_d    = res_idx_q;
    res_cnt_d    = res_cnt_q;
    frame_done_d = frame_end;
    if (res_valid_q && node_ready) begin
      res_valid_d = 1'b0;
    end
    if (window_end) begin
      res_valid_d = 1'b1;
      res_idx_d   = node_cnt_q;
      res_cnt_d   = sample_sum;
    end
  end

  // Datapath and output registers; reset drops any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q   <= '0;
      node_cnt_q   <= '0;
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      samp_cnt_q   <= samp_cnt_d;
      node_cnt_q   <= node_cnt_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_cnt_q    <= res_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign node_valid = res_valid_q;
  assign node_idx   = res_idx_q;
  assign node_count = res_cnt_q;
  assign frame_done = frame_done_q;

`ifdef RES_SAMPLER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a load hit a result the consumer has not taken
  always_comb begin
    overrun_d = overrun_q;
    if (start_accept) begin
      overrun_d = 1'b0;
    end else if (window_end && res_valid_q && !node_ready) begin
      overrun_d = 1'b1;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule : reservoir_node_sampler

// File: tb/tb_reservoir_node_sampler.sv
// Self-checking bench for reservoir_node_sampler (N_NODES=4, OVERSAMPLE=8).
// Expected node counts come from a cycle-indexed loop_in pattern: node j of a
// frame started at edge T counts loop_in values present at edges
// T-1+j*OS .. T-2+(j+1)*OS (two-flop synchronizer lag).
module tb_reservoir_node_sampler;

  localparam int N     = 4;
  localparam int OS    = 8;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;
  localparam int FRAME = N * OS;
`ifdef RES_SAMPLER_OVERRUN_EN
  localparam int OVR_EXP = 1;
`else
  localparam int OVR_EXP = 0;
`endif

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             loop_in = 1'b0;
  logic             start = 1'b0;
  logic             node_ready = 1'b0;
  logic             busy;
  logic             node_valid;
  logic [IDX_W-1:0] node_idx;
  logic [CNT_W-1:0] node_count;
  logic             frame_done;
  logic             overrun;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   mode         = 0;
  int   busy_end     = 0;
  int   last_t       = 0;
  bit   rnd_bits [1024];
  exp_t exp_q [$];
  int   fd_q [$];

  reservoir_node_sampler #(
    .N_NODES    (N),
    .OVERSAMPLE (OS),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .loop_in    (loop_in),
    .start      (start),
    .busy       (busy),
    .node_valid (node_valid),
    .node_ready (node_ready),
    .node_idx   (node_idx),
    .node_count (node_count),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // loop_in value present at edge c for pattern mode m
  function automatic bit loop_val(input int m, input int c);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return c[0];
      default: return rnd_bits[c % 1024];
    endcase
  endfunction

  // Edge counter and loop_in driver (value for the next edge)
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    loop_in = loop_val(mode, cyc + 1);
  end

  // Node result monitor: each handshake pops one expected result
  always @(negedge clk) begin
    if (rst_n && node_valid && node_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL node_unexpected: got idx=%0d count=%0d, required no pending result",
                 node_idx, node_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(node_idx) != e.idx || int'(node_count) != e.cnt) begin
          tests_failed++;
          $display("FAIL node_result: got idx=%0d count=%0d, required idx=%0d count=%0d",
                   node_idx, node_count, e.idx, e.cnt);
        end else begin
          $display("[TB] cycle %0d node idx=%0d count=%0d ok", cyc, node_idx, node_count);
        end
      end
    end
  end

  // frame_done monitor: pulse must land exactly on the expected cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) begin
        tests_run++;
        if (fd_q.size() != 0 && fd_q[0] == cyc) begin
          void'(fd_q.pop_front());
          $display("[TB] cycle %0d frame_done ok", cyc);
        end else begin
          tests_failed++;
          $display("FAIL frame_done_time: got pulse after edge %0d, required %0d",
                   cyc, (fd_q.size() != 0) ? fd_q[0] : -1);
        end
      end else if (fd_q.size() != 0 && cyc > fd_q[0]) begin
        tests_run++;
        tests_failed++;
        $display("FAIL frame_done_missing: got no pulse after edge %0d, required one",
                 fd_q[0]);
        void'(fd_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    repeat (3) tick();
  endtask

  // Pulse start for one edge; if the model says it is accepted, queue the
  // frame's expected results (only nodes flagged in keep get consumed)
  task automatic do_start(input bit [N-1:0] keep);
    int t;
    t = cyc + 1;
    start = 1'b1;
    if (t > busy_end) begin
      busy_end = t + FRAME;
      last_t   = t;
      for (int j = 0; j < N; j++) begin
        if (keep[j]) begin
          int sum;
          sum = 0;
          for (int e = t + 1 + j * OS; e <= t + (j + 1) * OS; e++) begin
            sum += int'(loop_val(mode, e - 2));
          end
          exp_q.push_back('{idx: j, cnt: sum});
        end
      end
      fd_q.push_back(t + FRAME);
      tick();
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
    end else begin
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_frame();
    while (cyc < busy_end) tick();
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    foreach (rnd_bits[i]) rnd_bits[i] = 1'($urandom_range(0, 1));

    // Reset state
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(node_valid), 0);
    check("rst_idx", int'(node_idx), 0);
    check("rst_count", int'(node_count), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    node_ready = 1'b1;

    // Constant high, toggling, constant low, then random patterns
    set_mode(1); do_start('1); wait_frame();
    check("overrun_clean", int'(overrun), 0);
    set_mode(2); do_start('1); wait_frame();
    set_mode(0); do_start('1); wait_frame();
    for (int k = 0; k < 3; k++) begin
      set_mode(3); do_start('1); wait_frame();
    end

    // Full backpressure: only the final node survives
    set_mode(3);
    node_ready = 1'b0;
    do_start(4'b1000);
    wait_frame();
    check("bp_valid", int'(node_valid), 1);
    check("bp_idx", int'(node_idx), N - 1);
    check("bp_overrun", int'(overrun), OVR_EXP);
    node_ready = 1'b1;
    tick();
    set_mode(1);
    do_start('1);
    check("overrun_cleared", int'(overrun), 0);
    wait_frame();

    // Ready pulsed only on the edges where the next result loads
    set_mode(3);
    node_ready = 1'b0;
    do_start('1);
    while (cyc < busy_end) begin
      node_ready = (((cyc + 1 - last_t) % OS) == 0) && ((cyc + 1 - last_t) >= 2 * OS);
      tick();
    end
    node_ready = 1'b1;
    check("pulse_overrun", int'(overrun), 0);
    tick();

    // Mid-frame start ignored, then back-to-back start in the frame_done cycle
    set_mode(2);
    do_start('1);
    repeat (10) tick();
    do_start('1);
    wait_frame();
    check("b2b_frame_done", int'(frame_done), 1);
    do_start('1);
    wait_frame();

    // Reset mid-frame with a result pending
    set_mode(3);
    node_ready = 1'b0;
    do_start('1);
    while (cyc < last_t + 13) tick();
    check("pre_rst_valid", int'(node_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(node_valid), 0);
    check("mid_rst_idx", int'(node_idx), 0);
    check("mid_rst_count", int'(node_count), 0);
    exp_q.delete();
    fd_q.delete();
    busy_end = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    node_ready = 1'b1;
    set_mode(3);
    do_start('1);
    wait_frame();

    // Drain: all queued expectations must have been observed
    for (int k = 0; k < 50 && (exp_q.size() != 0 || fd_q.size() != 0); k++) tick();
    check("drain_results", exp_q.size(), 0);
    check("drain_frame_done", fd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reservoir_node_sampler
